// File: rtl/mem_rd_arbiter_pkg.sv
// Shared definitions for the two-requester memory read arbiter:
// FSM state encoding and default bus widths.
package mem_rd_arbiter_pkg;

  localparam int unsigned DefAddrW = 17;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Avalon-style read-only port bundle.
//   addr/read          : command, driven by the master side
//   waitrequest        : command stall, driven by the slave side
//   readdata/readdatavalid : response, driven by the slave side
// The arbiter takes two slave modports (requesters) and one master modport (memory).
interface mem_rd_arbiter_if
  import mem_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output addr,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  addr,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/mem_rd_arbiter_id_fifo.sv
// Small FIFO recording which requester owns each outstanding read.
//   clk, nreset : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/wdata_i : enqueue wdata_i (ignored when full unless popping too)
//   pop_i       : dequeue head (ignored when empty)
//   head_o      : oldest entry, valid when !empty_o
//   full_o/empty_o : occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module mem_rd_arbiter_id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntFull);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Two-requester round-robin arbiter in front of one pipelined read port.
//   clk, nreset : clock, asynchronous active-low reset
//   m0, m1      : requester ports (command in, waitrequest/response out)
//   s           : shared memory port (command out, waitrequest/response in)
//   err         : sticky, set when memory returns data with nothing outstanding
// A grant costs one IDLE cycle, so at most one command is accepted every two cycles.
// Responses return in command order and are steered using an ID FIFO of grants.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             nreset,
  mem_rd_arbiter_if.slave  m0,
  mem_rd_arbiter_if.slave  m1,
  mem_rd_arbiter_if.master s,
  output logic             err
);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              push, pop;
  logic              fifo_head, fifo_full, fifo_empty;
  logic              sel_read;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_d          = last_q;
    push            = 1'b0;
    sel_read        = gnt_q ? m1.read : m0.read;
    sel_addr        = gnt_q ? m1.addr : m0.addr;
    s.addr          = sel_addr;
    s.read          = 1'b0;
    m0.waitrequest  = 1'b1;
    m1.waitrequest  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if ((m0.read || m1.read) && !fifo_full) begin
          state_d = StOwn;
          // On a tie the requester not served last wins.
          if (m0.read && m1.read) gnt_d = ~last_q;
          else                    gnt_d = m1.read;
        end
      end
      StOwn: begin
        s.read = sel_read;
        if (gnt_q) m1.waitrequest = s.waitrequest;
        else       m0.waitrequest = s.waitrequest;
        if (sel_read && !s.waitrequest) begin
          push    = 1'b1;
          last_d  = gnt_q;
          state_d = StIdle;
        end else if (!sel_read) begin
          // Requester withdrew: release without touching round-robin state.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rdata               = s.readdata;
  assign m0.readdata         = rdata;
  assign m1.readdata         = rdata;
  assign pop                 = s.readdatavalid && !fifo_empty;
  assign m0.readdatavalid    = pop && !fifo_head;
  assign m1.readdatavalid    = pop && fifo_head;
  assign err_d               = err_q || (s.readdatavalid && fifo_empty);
  assign err                 = err_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  mem_rd_arbiter_id_fifo #(
    .Width (1),
    .Depth (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (gnt_q),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
